// File: rtl/io_mmio_pkg.sv
// Shared register offsets, decode region and status-word layout for the MMIO responder.
package io_mmio_pkg;

  localparam logic [7:0] IO_UART_CTRL = 8'h00;
  localparam logic [7:0] IO_UART_RX   = 8'h04;
  localparam logic [7:0] IO_UART_TX   = 8'h08;
  localparam logic [7:0] IO_CYCLE_CNT = 8'h10;
  localparam logic [7:0] IO_INST_CNT  = 8'h14;
  localparam logic [7:0] IO_CNT_RST   = 8'h18;

  localparam logic [3:0] IO_REGION_DEFAULT = 4'h8;

  localparam int TX_FREE_BIT  = 0;
  localparam int RX_VALID_BIT = 1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head; push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/io_mmio_responder.sv
// MMIO target on the core data port: UART RX FIFO / TX holding register plus cycle and
// retired-instruction counters, with one-cycle registered read data like the block RAMs.
module io_mmio_responder
  import io_mmio_pkg::*;
#(
  parameter int          RX_FIFO_DEPTH = 8,
  parameter logic [3:0]  IO_REGION     = IO_REGION_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_en,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_we,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic        inst_retired
);

  logic        hit;
  logic        rd_hit;
  logic        wr_hit;
  logic [7:0]  offset;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_head;
  logic        fifo_push;
  logic        fifo_pop;
  logic        cnt_clr;
  logic [31:0] cycle_cnt;
  logic [31:0] inst_cnt;
  logic [31:0] status;
  logic [31:0] rd_mux;
  logic        unused_bits;

  assign hit       = req_en && (req_addr[31:28] == IO_REGION);
  assign rd_hit    = hit && (req_we == 4'b0000);
  assign wr_hit    = hit && (req_we != 4'b0000);
  assign offset    = req_addr[7:0];
  assign rx_ready  = !fifo_full;
  assign fifo_push = rx_valid && rx_ready;
  assign fifo_pop  = rd_hit && (offset == IO_UART_RX) && !fifo_empty;
  assign cnt_clr   = wr_hit && (offset == IO_CNT_RST);

  assign unused_bits = ^{req_addr[27:8], req_wdata[31:8]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (rx_data),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  always_comb begin
    status               = '0;
    status[TX_FREE_BIT]  = !tx_valid;
    status[RX_VALID_BIT] = !fifo_empty;
  end

  // Everything here is pre-update state, so reads see the request-cycle values.
  always_comb begin
    rd_mux = '0;
    case (offset)
      IO_UART_CTRL: rd_mux = status;
      IO_UART_RX:   rd_mux = fifo_empty ? 32'h0 : {24'h0, fifo_head};
      IO_CYCLE_CNT: rd_mux = cycle_cnt;
      IO_INST_CNT:  rd_mux = inst_cnt;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (rd_hit) begin
      rdata <= rd_mux;
    end
  end

  // A write landing while a byte is pending (even in its handshake cycle) is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else if (tx_valid) begin
      if (tx_ready) tx_valid <= 1'b0;
    end else if (wr_hit && (offset == IO_UART_TX) && req_we[0]) begin
      tx_data  <= req_wdata[7:0];
      tx_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cycle_cnt <= '0;
      inst_cnt  <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      inst_cnt  <= inst_cnt + {31'b0, inst_retired};
    end
  end

endmodule

// File: tb/tb_io_mmio_responder.sv
// Directed bench for io_mmio_responder: per-cycle vector table plus hand-written counter,
// wrap and mid-reset sequences.
module tb_io_mmio_responder;

  typedef struct {
    string       name;
    logic        en;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic        rxv;
    logic [7:0]  rxd;
    logic        txr;
    logic        inst;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        chk_tx;
    logic        exp_txv;
    logic [7:0]  exp_txd;
    logic        chk_rxr;
    logic        exp_rxr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_en = 1'b0;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_we = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] rdata;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        inst_retired = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  io_mmio_responder dut (
    .clk          (clk),
    .rst          (rst),
    .req_en       (req_en),
    .req_addr     (req_addr),
    .req_we       (req_we),
    .req_wdata    (req_wdata),
    .rdata        (rdata),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .inst_retired (inst_retired)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t f_idle(input string name);
    vec_t v;
    v.name = name;  v.en = 1'b0;  v.addr = '0;  v.we = '0;  v.wdata = '0;
    v.rxv = 1'b0;   v.rxd = '0;   v.txr = 1'b0; v.inst = 1'b0;
    v.chk_rd = 1'b0;  v.exp_rd = '0;
    v.chk_tx = 1'b0;  v.exp_txv = 1'b0;  v.exp_txd = '0;
    v.chk_rxr = 1'b0; v.exp_rxr = 1'b0;
    return v;
  endfunction

  function automatic vec_t f_rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
    vec_t v = f_idle(name);
    v.en = 1'b1;  v.addr = addr;  v.chk_rd = 1'b1;  v.exp_rd = exp;
    return v;
  endfunction

  function automatic vec_t f_wr(input string name, input logic [31:0] addr, input logic [3:0] we,
                                input logic [31:0] wdata);
    vec_t v = f_idle(name);
    v.en = 1'b1;  v.addr = addr;  v.we = we;  v.wdata = wdata;
    return v;
  endfunction

  function automatic vec_t with_tx(input vec_t vi, input logic txv, input logic [7:0] txd);
    vec_t v = vi;
    v.chk_tx = 1'b1;  v.exp_txv = txv;  v.exp_txd = txd;
    return v;
  endfunction

  function automatic vec_t with_rxr(input vec_t vi, input logic rxr);
    vec_t v = vi;
    v.chk_rxr = 1'b1;  v.exp_rxr = rxr;
    return v;
  endfunction

  // Drive one cycle from a falling edge, check registered results at the next falling edge.
  task automatic step(input vec_t v);
    req_en = v.en;  req_addr = v.addr;  req_we = v.we;  req_wdata = v.wdata;
    rx_valid = v.rxv;  rx_data = v.rxd;  tx_ready = v.txr;  inst_retired = v.inst;
    @(posedge clk);
    @(negedge clk);
    if (v.chk_rd) chk({v.name, ".rdata"}, rdata, v.exp_rd);
    if (v.chk_tx) begin
      chk({v.name, ".tx_valid"}, {31'b0, tx_valid}, {31'b0, v.exp_txv});
      if (v.exp_txv) chk({v.name, ".tx_data"}, {24'b0, tx_data}, {24'b0, v.exp_txd});
    end
    if (v.chk_rxr) chk({v.name, ".rx_ready"}, {31'b0, rx_ready}, {31'b0, v.exp_rxr});
  endtask

  vec_t tbl[$];

  initial begin
    vec_t v;

    v = with_tx(f_rd("status_reset", 32'h8000_0000, 32'h1), 1'b0, 8'h00);         tbl.push_back(v);
    v = with_tx(f_wr("tx_wr41", 32'h8000_0008, 4'b0001, 32'h0000_0041), 1'b1, 8'h41);
    v.chk_rd = 1'b1;  v.exp_rd = 32'h1;                                                tbl.push_back(v);
    v = with_tx(f_wr("tx_wr42_drop", 32'h8000_0008, 4'b0001, 32'h0000_0042), 1'b1, 8'h41);
    tbl.push_back(v);
    v = with_tx(f_idle("tx_hold"), 1'b1, 8'h41);                                       tbl.push_back(v);
    v = with_tx(f_rd("tx_handshake", 32'h8000_0000, 32'h0), 1'b0, 8'h00);
    v.txr = 1'b1;                                                                      tbl.push_back(v);
    v = with_tx(f_rd("status_txfree", 32'h8000_0000, 32'h1), 1'b0, 8'h00);          tbl.push_back(v);
    v = with_tx(f_wr("tx_wr5a", 32'h8000_0008, 4'b0001, 32'hFFFF_FF5A), 1'b1, 8'h5A);
    tbl.push_back(v);
    for (int i = 0; i < 8; i++) begin
      v = with_rxr(with_tx(f_idle("rx_fill"), 1'b1, 8'h5A), (i == 7) ? 1'b0 : 1'b1);
      v.rxv = 1'b1;  v.rxd = 8'(8'h10 + i);                                            tbl.push_back(v);
    end
    v = with_rxr(f_rd("status_full", 32'h8000_0000, 32'h2), 1'b0);
    v.rxv = 1'b1;  v.rxd = 8'h18;                                                      tbl.push_back(v);
    v = with_rxr(f_rd("rx_pop_full", 32'h8000_0004, 32'h10), 1'b1);
    v.rxv = 1'b1;  v.rxd = 8'h18;                                                      tbl.push_back(v);
    v = with_rxr(f_rd("rx_push_pop", 32'h8000_0004, 32'h11), 1'b1);
    v.rxv = 1'b1;  v.rxd = 8'h18;                                                      tbl.push_back(v);
    for (int i = 2; i < 8; i++) begin
      v = with_rxr(f_rd("rx_drain", 32'h8000_0004, 32'(32'h10 + i)), 1'b1);         tbl.push_back(v);
    end
    v = f_rd("rx_ninth", 32'h8000_0004, 32'h18);                                       tbl.push_back(v);
    v = f_rd("no_en", 32'h8000_0004, 32'h18);  v.en = 1'b0;                            tbl.push_back(v);
    v = f_rd("wrong_region", 32'h4000_0010, 32'h18);                                   tbl.push_back(v);
    v = f_rd("rx_empty", 32'h8000_0004, 32'h0);                                        tbl.push_back(v);
    v = with_rxr(f_rd("rx_empty_push", 32'h8000_0004, 32'h0), 1'b1);
    v.rxv = 1'b1;  v.rxd = 8'h55;                                                      tbl.push_back(v);
    v = f_rd("status_midbits", 32'h8FFF_FF00, 32'h2);                                  tbl.push_back(v);
    v = f_rd("unmapped", 32'h8000_0020, 32'h0);                                        tbl.push_back(v);
    v = f_rd("rx_55", 32'h8000_0004, 32'h55);                                          tbl.push_back(v);
    v = f_rd("read_wo_tx", 32'h8000_0008, 32'h0);                                      tbl.push_back(v);
    v = with_tx(f_idle("tx_release"), 1'b0, 8'h00);  v.txr = 1'b1;                     tbl.push_back(v);
    v = with_tx(f_wr("tx_lane1_only", 32'h8000_0008, 4'b0010, 32'h0000_9999), 1'b0, 8'h00);
    tbl.push_back(v);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset.rdata", rdata, 32'h0);
    chk("reset.tx_valid", {31'b0, tx_valid}, 32'h0);
    chk("reset.tx_data", {24'b0, tx_data}, 32'h0);
    chk("reset.rx_ready", {31'b0, rx_ready}, 32'h1);

    foreach (tbl[i]) step(tbl[i]);

    // Counters: restart from reset, 20 cycles with 5 retired instructions.
    rst = 1'b1;
    step(f_idle("cnt_rst"));
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      v = f_idle("cnt_run");
      v.inst = (i % 4 == 1) ? 1'b1 : 1'b0;
      step(v);
    end
    step(f_rd("cycle_cnt20", 32'h8000_0010, 32'd20));
    step(f_rd("inst_cnt5", 32'h8000_0014, 32'd5));
    v = f_wr("cnt_clr", 32'h8000_0018, 4'b1111, 32'h0);  v.inst = 1'b1;
    step(v);
    step(f_rd("cycle_after_clr", 32'h8000_0010, 32'd0));
    step(f_rd("inst_after_clr", 32'h8000_0014, 32'd0));

    // Wrap: preload the cycle counter with all ones.
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_cnt;
    step(f_rd("cycle_max", 32'h8000_0010, 32'hFFFF_FFFF));
    step(f_rd("cycle_wrap", 32'h8000_0010, 32'h0));

    // Mid-operation reset with a pending TX byte and three queued RX bytes.
    step(with_tx(f_wr("mr_tx", 32'h8000_0008, 4'b0001, 32'h77), 1'b1, 8'h77));
    for (int i = 0; i < 3; i++) begin
      v = f_idle("mr_rx");  v.rxv = 1'b1;  v.rxd = 8'(8'h61 + i);
      step(v);
    end
    step(f_rd("mr_status", 32'h8000_0000, 32'h2));
    rst = 1'b1;
    step(with_rxr(with_tx(f_rd("mr_rst_read", 32'h8000_0004, 32'h0), 1'b0, 8'h00), 1'b1));
    rst = 1'b0;
    step(f_rd("mr_status_after", 32'h8000_0000, 32'h1));
    step(f_rd("mr_rx_after", 32'h8000_0004, 32'h0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_mmio_responder.md
Name: io_mmio_responder

Overview:
- Memory-mapped I/O target answering core load/store requests in the 0x8xxx_xxxx address space.
- Bridges the core's synchronous-read data port to the on-chip UART ready/valid interfaces, with an RX byte FIFO and a TX holding register.
- Keeps cycle and retired-instruction counters readable by software.
- Sits beside dmem/imem on the core's data port; read data follows the same one-cycle read latency as the block RAMs.

Parameters:
- RX_FIFO_DEPTH, 8, RX byte FIFO entries; power of two, ≥2.
- IO_REGION, 4'h8, required value of addr[31:28] for a request to be decoded.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_en  in  1  bus request valid this cycle
- req_addr  in  32  byte address (ALU result)
- req_we  in  4  byte write enables; 4'b0000 = read
- req_wdata  in  32  write data, byte-lane aligned
- rdata  out  32  read data, valid the cycle after the read request
- rx_data  in  8  UART receiver byte
- rx_valid  in  1  UART receiver byte valid
- rx_ready  out  1  accept from UART receiver
- tx_data  out  8  byte to UART transmitter
- tx_valid  out  1  TX byte pending
- tx_ready  in  1  UART transmitter ready
- inst_retired  in  1  one-cycle pulse per retired instruction

Behaviour:
- Reset is synchronous, active-high, on `rst`; clock is `clk`. On reset: `rdata`=0, `tx_valid`=0, `tx_data`=0, FIFO empty, both counters=0. `rx_ready` is combinational `!full`, so it is 1 after reset.
- Decode: a request hits only when `req_en` and `req_addr[31:28]`==IO_REGION. Register offset = `req_addr[7:0]`; `req_addr[27:8]` is ignored. Read = `req_we`==0; write = any `req_we` bit set.
- Register map (offset, access, content):
  - 0x00, R: {30'b0, rx_nonempty, tx_free}. `tx_free`=!tx_valid.
  - 0x04, R: {24'b0, FIFO head}. A read pops one entry when non-empty; a read while empty returns 0 and does not pop.
  - 0x08, W: if `req_we[0]` and `tx_free`, load `tx_data`=`req_wdata[7:0]` and set `tx_valid`=1 next cycle. A write while `tx_valid`=1 is dropped silently.
  - 0x10, R: cycle counter.
  - 0x14, R: instruction counter.
  - 0x18, W: any write clears both counters.
- Unmapped offsets read 0. Writes to read-only offsets and reads of write-only offsets are ignored; such reads return 0.
- Read latency: `rdata` is registered and valid exactly 1 cycle after the request. `rdata` holds its previous value in cycles with no read hit.
- The status word and counter values returned are those present in the request cycle, before that cycle's updates.
- RX FIFO:
  - Push on `rx_valid` && `rx_ready`.
  - Pop on a 0x04 read hit when non-empty.
  - Simultaneous push and pop on a non-empty FIFO: count unchanged; head data is returned and advanced.
  - Push into an empty FIFO while a 0x04 read is in the same cycle: the read returns 0 and does not pop; the byte is stored.
  - Full: `rx_ready`=0, so the UART holds its byte and no data is lost. Pointers wrap modulo RX_FIFO_DEPTH.
- TX: `tx_valid` stays high, with `tx_data` stable, until a cycle with `tx_ready`=1. It clears on the following edge. A new write can be accepted starting the cycle after `tx_valid` falls.
- Counters: 32-bit, wrap 0xFFFF_FFFF→0.
  - Cycle counter increments every cycle out of reset.
  - Instruction counter increments on `inst_retired`.
  - A 0x18 write in the same cycle as an increment: clear wins, and the counter is 0 next cycle.
- Reset mid-operation: a pending TX byte is discarded and FIFO contents are lost. A read issued in the reset cycle produces `rdata`=0.
- The core holds `req_en` low during pipeline stalls; the block assumes one request per asserted cycle.

Decomposition:
- Shared package `io_mmio_pkg`:
  - offset localparams: IO_UART_CTRL=8'h00, IO_UART_RX=8'h04, IO_UART_TX=8'h08, IO_CYCLE_CNT=8'h10, IO_INST_CNT=8'h14, IO_CNT_RST=8'h18
  - IO_REGION default
  - status bit indices TX_FREE_BIT=0, RX_VALID_BIT=1
- One sub-module, `sync_fifo`: parameterised width and depth, with push/pop/full/empty/head, first-word visible on head, synchronous reset.

Test Plan:
- TX write: reset; read 0x8000_0000 → `rdata`=0x1 next cycle. Write 0x8000_0008 with data 0x41 and `we`=4'b0001 while `tx_ready`=0 → `tx_valid`=1 with `tx_data`=0x41 held. A second write of 0x42 is dropped. Raise `tx_ready` → `tx_valid` falls after 1 cycle; status reads 0x1.
- RX FIFO: drive 8 RX bytes 0x10..0x17 with 0x8000_0004 unread → `rx_ready`=0 after the 8th byte and the 9th byte 0x18 is stalled. Status reads 0x2. Eight reads of 0x04 return 0x10..0x17 in order, then the 9th read returns 0x18.
- Empty RX: read 0x04 with the FIFO empty → `rdata`=0. Same-cycle push 0x55 with a 0x04 read on an empty FIFO → that read returns 0; the next read returns 0x55.
- Counters: 20 cycles after reset with 5 `inst_retired` pulses → 0x10 read returns 20 (counter value in the request cycle) and 0x14 returns 5. Write 0x18 in a cycle with `inst_retired`=1 → both counters read 0 or 1 (elapsed cycles) afterwards; instruction counter = 0.
- Decode: read 0x4000_0010 → no update; `rdata` keeps its prior value. Read 0x8000_0020 → 0. Wrap: force cycle counter to 0xFFFF_FFFF → next value is 0.
- Mid-reset: pending `tx_valid`=1 and 3 bytes in the FIFO; pulse `rst` → `tx_valid`=0, status reads 0x1, and a 0x04 read returns 0.
